// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out transmitter.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } piso_state_t;

    localparam int WIDTH_DEF     = 8;
    localparam int LSB_FIRST_DEF = 1;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit load/shift register. dir_i=1 shifts right and presents bit 0,
// dir_i=0 shifts left and presents the top bit; vacated positions fill with 0.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             out_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    // Load wins over shift so a back-to-back word replaces the drained register.
    always_comb begin
        sr_d = sr_q;
        if (load_i)
            sr_d = din_i;
        else if (shift_i)
            sr_d = dir_i ? (sr_q >> 1) : (sr_q << 1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    assign out_o = dir_i ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load and frame markers.
// Build option: PISO_PARITY_EN adds a PAR state that sends even parity after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int LSB_FIRST = LSB_FIRST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last,
    output logic             busy
);

    localparam int              CNT_W    = (cnt_w(WIDTH) > 0) ? cnt_w(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             so_valid_q, so_valid_d;
    logic             so_first_q, so_first_d;
    logic             so_last_q, so_last_d;
    logic             accept, final_bit, sr_out;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign final_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

`ifdef PISO_PARITY_EN
    assign din_ready = !rst && ((state_q == IDLE) || (state_q == PAR));
`else
    assign din_ready = !rst && ((state_q == IDLE) || final_bit);
`endif

    assign accept = din_valid && din_ready;

    // State register, including the registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            so_valid_q <= 1'b0;
            so_first_q <= 1'b0;
            so_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            so_valid_q <= so_valid_d;
            so_first_q <= so_first_d;
            so_last_q  <= so_last_d;
`ifdef PISO_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = accept ? ^din : par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (final_bit) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAR: begin
                cnt_d   = '0;
                state_d = accept ? SHIFT : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: frame markers for the cycle after this edge.
    always_comb begin
        so_valid_d = (state_d != IDLE);
        so_first_d = accept;
`ifdef PISO_PARITY_EN
        so_last_d  = (state_d == PAR);
`else
        so_last_d  = (state_d == SHIFT) && (cnt_d == LAST_IDX);
`endif
    end

    piso_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (state_q == SHIFT),
        .dir_i   (LSB_FIRST != 0),
        .din_i   (din),
        .out_o   (sr_out)
    );

    // Gated by so_valid so an aborted frame cannot leave stale data on the line.
`ifdef PISO_PARITY_EN
    assign so = so_valid_q && ((state_q == PAR) ? par_q : sr_out);
`else
    assign so = so_valid_q && sr_out;
`endif

    assign so_valid = so_valid_q;
    assign so_first = so_first_q;
    assign so_last  = so_last_q;
    assign busy     = so_valid_q;

endmodule
